// File: rtl/float_divider_bf16.sv
// Iterative bf16 (parameterisable) divider: radix-2 restoring mantissa divide then RNE rounding.
// Optional exception flags output enabled by defining FLOAT_DIVIDER_BF16_FLAGS_EN.
module float_divider_bf16 #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7,
    parameter int unsigned BIAS  = 127
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   is_output_valid,
    input  logic                   out_ready
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
    ,
    output logic [4:0]             flags
`endif
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned QW   = MAN_W + 4;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned CW   = $clog2(QW + 1);
    localparam int unsigned EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StDivide, StRound, StDone} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q;
    logic [EW-1:0]    exp_q;
    logic [MAN_W+1:0] rem_q;
    logic [MAN_W:0]   div_q;
    logic [QW-1:0]    quo_q;

    // Operand unpack; exponent-zero operands (including subnormals) count as zero.
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             sign_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EW-1:0]    exp_in;

    assign ea      = a[W-2:MAN_W];
    assign eb      = b[W-2:MAN_W];
    assign ma      = a[MAN_W-1:0];
    assign mb      = b[MAN_W-1:0];
    assign sign_in = a[W-1] ^ b[W-1];
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == '1) && (ma == '0);
    assign b_inf   = (eb == '1) && (mb == '0);
    assign a_nan   = (ea == '1) && (ma != '0);
    assign b_nan   = (eb == '1) && (mb != '0);
    assign exp_in  = {2'b00, ea} - {2'b00, eb} + EW'(BIAS);

    logic         spec_hit;
    logic [W-1:0] spec_y;

    always_comb begin
        spec_hit = 1'b1;
        spec_y   = {sign_in, {(W-1){1'b0}}};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_y = NAN;
        end else if (b_zero || a_inf) begin
            spec_y = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
            spec_y = {sign_in, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step; remainder stays below twice the divisor.
    logic             rem_ge;
    logic [MAN_W+1:0] rem_sub, rem_nxt;

    assign rem_ge  = (rem_q >= {1'b0, div_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    assign rem_nxt = {rem_sub[MAN_W:0], 1'b0};

    logic [QW-1:0]  quo_n;
    logic [EW-1:0]  exp_n, exp_r;
    logic [MAN_W-1:0] man_t;
    logic [MAN_W:0] man_r;
    logic           guard, sticky, inc, ovf, unf;
    logic [W-1:0]   round_y;

    always_comb begin
        quo_n   = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
        exp_n   = quo_q[QW-1] ? exp_q : (exp_q - EW'(1));
        man_t   = quo_n[QW-2:3];
        guard   = quo_n[2];
        sticky  = (|quo_n[1:0]) | (|rem_q);
        inc     = guard & (sticky | man_t[0]);
        man_r   = {1'b0, man_t} + (MAN_W+1)'(inc);
        exp_r   = man_r[MAN_W] ? (exp_n + EW'(1)) : exp_n;
        unf     = exp_r[EW-1] || (exp_r == '0);
        ovf     = !exp_r[EW-1] && (exp_r[EW-2:0] >= (EW-1)'(EMAX));
        round_y = {sign_q, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
        if (ovf) begin
            round_y = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            round_y = {sign_q, {(W-1){1'b0}}};
        end
    end

`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
    logic       spec_inv, spec_dbz, inexact_r;
    logic [4:0] flags_q;

    assign spec_inv  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    assign spec_dbz  = b_zero && !a_zero && !a_inf && !a_nan && !b_nan;
    assign inexact_r = guard | sticky | ovf | unf;
    assign flags     = flags_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            in_ready        <= 1'b0;
            y               <= '0;
            is_output_valid <= 1'b0;
            cnt_q           <= '0;
            sign_q          <= 1'b0;
            exp_q           <= '0;
            rem_q           <= '0;
            div_q           <= '0;
            quo_q           <= '0;
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
            flags_q         <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_q   <= sign_in;
                        exp_q    <= exp_in;
                        rem_q    <= {1'b0, 1'b1, ma};
                        div_q    <= {1'b1, mb};
                        quo_q    <= '0;
                        cnt_q    <= '0;
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
                        flags_q  <= {spec_inv, spec_dbz, 3'b000};
`endif
                        if (spec_hit) begin
                            y       <= spec_y;
                            state_q <= StDone;
                        end else begin
                            state_q <= StDivide;
                        end
                    end
                end
                StDivide: begin
                    quo_q <= {quo_q[QW-2:0], rem_ge};
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) begin
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    y       <= round_y;
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
                    flags_q <= {2'b00, ovf, unf, inexact_r};
`endif
                    state_q <= StDone;
                end
                StDone: begin
                    // First DONE cycle publishes the result; later ones wait for the consumer.
                    if (!is_output_valid) begin
                        is_output_valid <= 1'b1;
                    end else if (out_ready) begin
                        is_output_valid <= 1'b0;
                        in_ready        <= 1'b1;
                        state_q         <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_divider_bf16.sv
// Directed, table-driven bench for float_divider_bf16 (bf16 defaults), plus backpressure and
// mid-operation reset sequences.
module tb_float_divider_bf16;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] a, b, y;
    logic        in_valid, in_ready, is_output_valid, out_ready;
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
    logic [4:0]  flags;
`endif

    int errors = 0;
    int checks = 0;

    float_divider_bf16 dut (
        .clock           (clock),
        .reset           (reset),
        .a               (a),
        .b               (b),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .y               (y),
        .is_output_valid (is_output_valid),
        .out_ready       (out_ready)
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
        ,
        .flags           (flags)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic [4:0]  fl;
        int          lat;
        bit          hold;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one operation and wait for its result; leaves the result unconsumed.
    task automatic do_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] ey, input logic [4:0] ef, input int elat,
                         input bit hold, input logic [15:0] na, input logic [15:0] nb);
        int n;
        int lat;
        bit rdy_seen;
        a = va;
        b = vb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            check({name, " in_ready wait"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        a = na;
        b = nb;
        in_valid = hold;
        lat = 0;
        rdy_seen = 1'b0;
        while (!is_output_valid && lat < 40) begin
            rdy_seen |= in_ready;
            @(posedge clock); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " y"}, {16'h0, y}, {16'h0, ey});
        check({name, " in_ready low"}, 32'(rdy_seen), 32'd0);
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
        check({name, " flags"}, 32'(flags), 32'(ef));
`else
        if (ef === 5'bx) $display("note: unknown expected flags for %s", name);
`endif
    endtask

    initial begin
        logic [15:0] na, nb;

        vecs[0]  = '{"one_by_two",   16'h3F80, 16'h4000, 16'h3F00, 5'b00000, 13, 1'b0};
        vecs[1]  = '{"neg6_by_2",    16'hC0C0, 16'h4000, 16'hC040, 5'b00000, 13, 1'b1};
        vecs[2]  = '{"three_by_1p5", 16'h4040, 16'h3FC0, 16'h4000, 5'b00000, 13, 1'b0};
        vecs[3]  = '{"one_third",    16'h3F80, 16'h4040, 16'h3EAB, 5'b00001, 13, 1'b0};
        vecs[4]  = '{"neg_third",    16'hBF80, 16'h4040, 16'hBEAB, 5'b00001, 13, 1'b0};
        vecs[5]  = '{"one_by_zero",  16'h3F80, 16'h0000, 16'h7F80, 5'b01000, 1,  1'b0};
        vecs[6]  = '{"zero_by_zero", 16'h0000, 16'h0000, 16'h7FC0, 5'b10000, 1,  1'b0};
        vecs[7]  = '{"zero_by_neg1", 16'h0000, 16'hBF80, 16'h8000, 5'b00000, 1,  1'b0};
        vecs[8]  = '{"overflow",     16'h7F7F, 16'h3E80, 16'h7F80, 5'b00101, 13, 1'b0};
        vecs[9]  = '{"inf_by_inf",   16'h7F80, 16'h7F80, 16'h7FC0, 5'b10000, 1,  1'b0};
        vecs[10] = '{"nan_operand",  16'h7FC1, 16'h3F80, 16'h7FC0, 5'b10000, 1,  1'b0};
        vecs[11] = '{"inf_by_neg2",  16'h7F80, 16'hC000, 16'hFF80, 5'b00000, 1,  1'b0};
        vecs[12] = '{"two_by_ninf",  16'h4000, 16'hFF80, 16'h8000, 5'b00000, 1,  1'b0};
        vecs[13] = '{"subnormal_a",  16'h0001, 16'h3F80, 16'h0000, 5'b00000, 1,  1'b0};
        vecs[14] = '{"underflow",    16'h0080, 16'h4000, 16'h0000, 5'b00011, 13, 1'b0};
        vecs[15] = '{"max_by_one",   16'h7F7F, 16'h3F80, 16'h7F7F, 5'b00000, 13, 1'b0};
        vecs[16] = '{"neg1_by_nz",   16'hBF80, 16'h8000, 16'h7F80, 5'b01000, 1,  1'b0};
        vecs[17] = '{"inf_by_zero",  16'h7F80, 16'h0000, 16'h7F80, 5'b00000, 1,  1'b0};
        vecs[18] = '{"one_by_one",   16'h3F80, 16'h3F80, 16'h3F80, 5'b00000, 13, 1'b0};

        reset = 1'b0;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset y", {16'h0, y}, 32'h0);
        check("reset valid", 32'(is_output_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
`ifdef FLOAT_DIVIDER_BF16_FLAGS_EN
        check("reset flags", 32'(flags), 32'd0);
`endif
        reset = 1'b1;
        @(posedge clock); #1;
        check("in_ready after release", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            na = ~vecs[i].a;
            nb = ~vecs[i].b;
            if (vecs[i].hold && (i + 1 < NV)) begin
                na = vecs[i+1].a;
                nb = vecs[i+1].b;
            end
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].fl, vecs[i].lat,
                  vecs[i].hold, na, nb);
        end

        // Let the last result be consumed, then hold off the consumer.
        @(posedge clock); #1;
        out_ready = 1'b0;
        do_op("backpressure", 16'h3F80, 16'h4000, 16'h3F00, 5'b00000, 13, 1'b0, 16'h1234,
              16'h5678);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("bp valid held", 32'(is_output_valid), 32'd1);
            check("bp y held", {16'h0, y}, 32'h3F00);
            check("bp in_ready low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp valid cleared", 32'(is_output_valid), 32'd0);
        check("bp in_ready back", 32'(in_ready), 32'd1);
        check("bp y retained", {16'h0, y}, 32'h3F00);

        // Abort during the fourth DIVIDE cycle.
        a = 16'h4040;
        b = 16'h3FC0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort y", {16'h0, y}, 32'h0);
        check("abort valid", 32'(is_output_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        do_op("after_abort", 16'h3F80, 16'h3F80, 16'h3F80, 5'b00000, 13, 1'b0, 16'h0,
              16'h0);
        @(posedge clock); #1;
        check("after_abort consumed", 32'(is_output_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
